// File: rtl/captura_temperatura_ps2.sv
// captura_temperatura_ps2
// Keyboard temperature-entry stage placed after the PS/2 receiver. Collects one
// or two set-2 digit make codes, commits them on Enter as a 0..99 binary value
// and strobes temp_valid. Backspace drops the last digit, Esc drops the entry,
// and an idle entry is dropped after TIMEOUT_CYCLES with an entry_error pulse.
// Optional build macro: KEYPAD_DIGITS_EN (numeric keypad digits also accepted).
module captura_temperatura_ps2 #(
  parameter int TIMEOUT_W      = 28,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_done_tick,
  input  logic [7:0] i_dout,
  output logic [6:0] o_temp,
  output logic       o_temp_valid,
  output logic       o_entry_active,
  output logic [1:0] o_digit_count,
  output logic       o_entry_error
);

  // State encoding equals the number of held digits, so digit_count is the state register.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_D1   = 2'd1,
    S_D2   = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] LP_CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] LP_BREAK = 8'hF0;
  localparam logic [7:0] LP_EXT   = 8'hE0;
  localparam logic [7:0] LP_ENTER = 8'h5A;
  localparam logic [7:0] LP_BKSP  = 8'h66;
  localparam logic [7:0] LP_ESC   = 8'h76;

  // Maps a scan code to {is_digit, digit_value}.
  function automatic logic [4:0] f_digit(input logic [7:0] code);
    logic [4:0] res;
    case (code)
      8'h45:   res = {1'b1, 4'd0};
      8'h16:   res = {1'b1, 4'd1};
      8'h1E:   res = {1'b1, 4'd2};
      8'h26:   res = {1'b1, 4'd3};
      8'h25:   res = {1'b1, 4'd4};
      8'h2E:   res = {1'b1, 4'd5};
      8'h36:   res = {1'b1, 4'd6};
      8'h3D:   res = {1'b1, 4'd7};
      8'h3E:   res = {1'b1, 4'd8};
      8'h46:   res = {1'b1, 4'd9};
`ifdef KEYPAD_DIGITS_EN
      8'h70:   res = {1'b1, 4'd0};
      8'h69:   res = {1'b1, 4'd1};
      8'h72:   res = {1'b1, 4'd2};
      8'h7A:   res = {1'b1, 4'd3};
      8'h6B:   res = {1'b1, 4'd4};
      8'h73:   res = {1'b1, 4'd5};
      8'h74:   res = {1'b1, 4'd6};
      8'h6C:   res = {1'b1, 4'd7};
      8'h75:   res = {1'b1, 4'd8};
      8'h7D:   res = {1'b1, 4'd9};
`endif
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_d_hi;
  logic [3:0]           w_d_hi_nxt;
  logic [3:0]           r_d_lo;
  logic [3:0]           w_d_lo_nxt;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_nxt;
  logic                 r_break;
  logic                 w_break_nxt;
  logic [6:0]           r_temp;
  logic [6:0]           w_temp_nxt;
  logic                 r_temp_valid;
  logic                 w_temp_valid_nxt;
  logic                 r_entry_error;
  logic                 w_entry_error_nxt;
  logic                 r_entry_active;

  logic                 w_make;
  logic [4:0]           w_digit_code;
  logic                 w_is_digit;
  logic                 w_is_enter;
  logic                 w_is_bksp;
  logic                 w_is_esc;
  logic                 w_key;
  logic [6:0]           w_hi_x8;
  logic [6:0]           w_hi_x2;
  logic [6:0]           w_value2;

  // A make code is any byte that is neither a prefix nor the byte following a break prefix.
  assign w_make       = i_rx_done_tick && (i_dout != LP_BREAK) && (i_dout != LP_EXT) && !r_break;
  assign w_digit_code = f_digit(i_dout);
  assign w_is_digit   = w_make && w_digit_code[4];
  assign w_is_enter   = w_make && (i_dout == LP_ENTER);
  assign w_is_bksp    = w_make && (i_dout == LP_BKSP);
  assign w_is_esc     = w_make && (i_dout == LP_ESC);
  assign w_key        = w_is_digit || w_is_enter || w_is_bksp || w_is_esc;

  // 10*d_hi built from shifts; 99 is the largest result so 7 bits never overflow.
  assign w_hi_x8  = {r_d_hi, 3'b000};
  assign w_hi_x2  = {2'b00, r_d_hi, 1'b0};
  assign w_value2 = w_hi_x8 + w_hi_x2 + {3'b000, r_d_lo};

  // Next-state, held digits, commit value, strobes and inactivity counter.
  always_comb begin
    w_state_nxt       = r_state;
    w_d_hi_nxt        = r_d_hi;
    w_d_lo_nxt        = r_d_lo;
    w_temp_nxt        = r_temp;
    w_temp_valid_nxt  = 1'b0;
    w_entry_error_nxt = 1'b0;
    w_break_nxt       = r_break;

    if (i_rx_done_tick) begin
      if (i_dout == LP_BREAK) begin
        w_break_nxt = 1'b1;
      end else begin
        w_break_nxt = 1'b0;
      end
    end else begin
      w_break_nxt = r_break;
    end

    if (w_key) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_digit) begin
            w_d_hi_nxt  = w_digit_code[3:0];
            w_state_nxt = S_D1;
          end else if (w_is_enter) begin
            w_entry_error_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_D1: begin
          if (w_is_digit) begin
            w_d_lo_nxt  = w_digit_code[3:0];
            w_state_nxt = S_D2;
          end else if (w_is_enter) begin
            w_temp_nxt       = {3'b000, r_d_hi};
            w_temp_valid_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_D2: begin
          if (w_is_digit) begin
            w_entry_error_nxt = 1'b1;
          end else if (w_is_enter) begin
            w_temp_nxt       = w_value2;
            w_temp_valid_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
          end else if (w_is_bksp) begin
            w_state_nxt = S_D1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else if ((r_state != S_IDLE) && (r_cnt == LP_CNT_LAST)) begin
      w_state_nxt       = S_IDLE;
      w_entry_error_nxt = 1'b1;
    end else begin
      w_state_nxt = r_state;
    end

    // Counter restarts on every accepted key and whenever the entry is idle.
    w_cnt_nxt = (w_key || (w_state_nxt == S_IDLE)) ? {TIMEOUT_W{1'b0}}
                                                   : r_cnt + TIMEOUT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_d_hi         <= 4'd0;
      r_d_lo         <= 4'd0;
      r_cnt          <= {TIMEOUT_W{1'b0}};
      r_break        <= 1'b0;
      r_temp         <= 7'd0;
      r_temp_valid   <= 1'b0;
      r_entry_error  <= 1'b0;
      r_entry_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_d_hi         <= w_d_hi_nxt;
      r_d_lo         <= w_d_lo_nxt;
      r_cnt          <= w_cnt_nxt;
      r_break        <= w_break_nxt;
      r_temp         <= w_temp_nxt;
      r_temp_valid   <= w_temp_valid_nxt;
      r_entry_error  <= w_entry_error_nxt;
      r_entry_active <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_temp         = r_temp;
  assign o_temp_valid   = r_temp_valid;
  assign o_entry_error  = r_entry_error;
  assign o_entry_active = r_entry_active;
  assign o_digit_count  = r_state;

endmodule

// File: tb/tb_captura_temperatura_ps2.sv
// Testbench for captura_temperatura_ps2: directed scenarios followed by random
// scan-code traffic. A per-cycle reference model (digits kept as a list) pushes
// expected outputs into a scoreboard queue; a monitor pops and compares.
module tb_captura_temperatura_ps2;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_tick = 1'b0;
  logic [7:0] dout = 8'h00;
  logic [6:0] temp;
  logic       temp_valid;
  logic       entry_active;
  logic [1:0] digit_count;
  logic       entry_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int temp;
    bit valid;
    bit err;
    int cnt;
  } exp_t;
  exp_t sb[$];

  // Reference model state.
  int m_digits[$];
  bit m_brk  = 1'b0;
  int m_idle = 0;
  int m_temp = 0;

  captura_temperatura_ps2 #(.TIMEOUT_W(28), .TIMEOUT_CYCLES(T)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_rx_done_tick(rx_tick),
    .i_dout        (dout),
    .o_temp        (temp),
    .o_temp_valid  (temp_valid),
    .o_entry_active(entry_active),
    .o_digit_count (digit_count),
    .o_entry_error (entry_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Returns 0..9 for a digit key, 10 Enter, 11 Backspace, 12 Esc, -1 otherwise.
  function automatic int classify(input logic [7:0] b);
    logic [7:0] top[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pad[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    for (int i = 0; i < 10; i++) begin
      if (b == top[i]) return i;
`ifdef KEYPAD_DIGITS_EN
      if (b == pad[i]) return i;
`else
      if (b == pad[i]) return -1;
`endif
    end
    if (b == 8'h5A) return 10;
    if (b == 8'h66) return 11;
    if (b == 8'h76) return 12;
    return -1;
  endfunction

  // Advances the model by one clock edge and queues the expected outputs.
  task automatic model_step(input bit rx, input logic [7:0] b);
    exp_t e;
    int   key;
    int   v;
    e.valid = 1'b0;
    e.err   = 1'b0;
    key     = -1;
    if (rx) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else if (m_brk) m_brk = 1'b0;
      else if (b != 8'hE0) key = classify(b);
    end
    if (key >= 0) begin
      m_idle = 0;
      if (key <= 9) begin
        if (m_digits.size() < 2) m_digits.push_back(key);
        else e.err = 1'b1;
      end else if (key == 10) begin
        if (m_digits.size() == 0) begin
          e.err = 1'b1;
        end else begin
          v = 0;
          foreach (m_digits[i]) v = v * 10 + m_digits[i];
          m_temp  = v;
          e.valid = 1'b1;
          m_digits.delete();
        end
      end else if (key == 11) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
      end else begin
        m_digits.delete();
      end
    end else if (m_digits.size() > 0) begin
      m_idle++;
      if (m_idle == T) begin
        e.err = 1'b1;
        m_digits.delete();
      end
    end
    if (m_digits.size() == 0) m_idle = 0;
    e.temp = m_temp;
    e.cnt  = m_digits.size();
    sb.push_back(e);
  endtask

  task automatic tick(input bit rx, input logic [7:0] b);
    @(negedge clk);
    rx_tick = rx;
    dout    = b;
    model_step(rx, b);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    tick(1'b1, b);
    repeat (gap) tick(1'b0, 8'h00);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i], 1);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    rx_tick = 1'b0;
  endtask

  // Scoreboard monitor: compares every queued expectation one step after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("temp_valid", int'(temp_valid), int'(e.valid));
        chk("entry_error", int'(entry_error), int'(e.err));
        chk("temp", int'(temp), e.temp);
        chk("digit_count", int'(digit_count), e.cnt);
        chk("entry_active", int'(entry_active), int'(e.cnt > 0));
      end
    end
  end

  initial begin
    int r;
    logic [7:0] b;
    logic [7:0] pool_top[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool_pad[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    #1 rst = 1'b1;
    #3;
    chk("reset_temp", int'(temp), 0);
    chk("reset_temp_valid", int'(temp_valid), 0);
    chk("reset_entry_active", int'(entry_active), 0);
    chk("reset_digit_count", int'(digit_count), 0);
    chk("reset_entry_error", int'(entry_error), 0);
    @(negedge clk);
    rst = 1'b0;

    // Two digits with break codes interleaved.
    send_seq('{8'h1E, 8'hF0, 8'h1E, 8'h46, 8'hF0, 8'h46, 8'h5A, 8'hF0, 8'h5A});
    chk("seq1_temp", int'(temp), 29);
    chk("seq1_count", int'(digit_count), 0);

    // Single digit, then Enter with nothing held.
    send_seq('{8'h26, 8'h5A});
    chk("seq2_temp", int'(temp), 3);
    send_seq('{8'h5A});
    chk("seq2_temp_kept", int'(temp), 3);

    // Third digit rejected, then Backspace and re-entry.
    send_seq('{8'h16, 8'h25, 8'h2E});
    chk("seq3_count", int'(digit_count), 2);
    send_seq('{8'h66, 8'h3D, 8'h5A});
    chk("seq3_temp", int'(temp), 17);

    // Timeout of a partial entry.
    send(8'h36, T + 2);
    chk("seq4_active", int'(entry_active), 0);
    send_seq('{8'h5A});
    chk("seq4_temp", int'(temp), 17);

    // Esc, zero value, then reset mid-entry.
    send_seq('{8'h3E, 8'h76, 8'h45, 8'h5A});
    chk("seq5_temp", int'(temp), 0);
    send_seq('{8'h16, 8'h3D, 8'h5A});
    chk("seq5_temp17", int'(temp), 17);
    send(8'h45, 1);
    drain();
    rst = 1'b1;
    #1;
    chk("midreset_temp", int'(temp), 0);
    chk("midreset_count", int'(digit_count), 0);
    chk("midreset_active", int'(entry_active), 0);
    chk("midreset_valid", int'(temp_valid), 0);
    chk("midreset_error", int'(entry_error), 0);
    @(negedge clk);
    rst = 1'b0;
    m_digits.delete();
    m_brk  = 1'b0;
    m_idle = 0;
    m_temp = 0;

    // Extended Enter and keypad digits.
    send_seq('{8'h46, 8'hE0, 8'h5A});
    chk("seq6_temp", int'(temp), 9);
    send_seq('{8'h72, 8'h7D, 8'h5A});
`ifdef KEYPAD_DIGITS_EN
    chk("seq6_keypad_temp", int'(temp), 29);
`else
    chk("seq6_keypad_temp", int'(temp), 9);
`endif

    // Random scan-code traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) b = pool_top[$urandom_range(0, 9)];
      else if (r < 50) b = 8'hF0;
      else if (r < 55) b = 8'hE0;
      else if (r < 65) b = 8'h5A;
      else if (r < 72) b = 8'h66;
      else if (r < 77) b = 8'h76;
      else if (r < 85) b = pool_pad[$urandom_range(0, 9)];
      else b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) send(b, $urandom_range(T - 2, T + 3));
      else send(b, $urandom_range(0, 3));
    end

    repeat (T + 3) tick(1'b0, 8'h00);
    drain();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
